wb_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 16 +
 rtl/wb_stage_if.sv | 34 +++
 rtl/load_extend.sv | 36 +++
 rtl/wb_stage.sv | 116 +++++++++++
 tb/tb_wb_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: load funct3 encodings and the write-back FSM states.
package pipeline_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      PEND  = 2'd1,
      READY = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake and register-file write port, grouped for the write-back stage.
interface wb_stage_if #(
   parameter int unsigned XLEN = 32
) ();

   logic            mem_valid;
   logic            mem_RegWrite;
   logic            mem_MemtoReg;
   logic            mem_is_jal;
   logic [2:0]      mem_funct3;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_pc_plus4;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;
   logic            wb_stall;
   logic [XLEN-1:0] Write_data;
   logic [4:0]      Write_register;
   logic            RegWrite;
   logic [63:0]     instret;

   modport master (
      output mem_valid, mem_RegWrite, mem_MemtoReg, mem_is_jal, mem_funct3, mem_rd,
             mem_alu_result, mem_pc_plus4, dmem_rvalid, dmem_rdata,
      input  wb_stall, Write_data, Write_register, RegWrite, instret
   );

   modport slave (
      input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_is_jal, mem_funct3, mem_rd,
             mem_alu_result, mem_pc_plus4, dmem_rvalid, dmem_rdata,
      output wb_stall, Write_data, Write_register, RegWrite, instret
   );

endinterface

// File: rtl/load_extend.sv
// Combinational load extraction: picks the byte/halfword/word at the load offset and extends it.
module load_extend
   import pipeline_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      half_sel = 16'h0000;
      data     = word;
      unique case (off)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = off[1] ? word[31:16] : word[15:0];
      // Unlisted encodings fall through to a full-word load.
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'h000000, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'h0000, half_sel};
         F3_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB entry, load-data wait with back-pressure, result select and commit.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic        clk,
   input logic        rst,
   wb_stage_if.slave  wb
);

   wb_state_t       state_q, state_d;
   logic            ent_v_q, ent_v_d;
   logic            ent_regwrite_q, ent_regwrite_d;
   logic [4:0]      ent_rd_q, ent_rd_d;
   logic [2:0]      ent_funct3_q, ent_funct3_d;
   logic [1:0]      ent_off_q, ent_off_d;
   logic [XLEN-1:0] ent_data_q, ent_data_d;

   logic            stall;
   logic            capture;
   logic [31:0]     ext_data;

   load_extend u_load_extend (
      .word   (wb.dmem_rdata),
      .funct3 (ent_funct3_q),
      .off    (ent_off_q),
      .data   (ext_data)
   );

   // Stall decodes state only, keeping memory response off the stall path.
   assign stall   = (state_q == PEND);
   assign capture = wb.mem_valid && !stall;

   always_comb begin
      state_d        = state_q;
      ent_v_d        = ent_v_q;
      ent_regwrite_d = ent_regwrite_q;
      ent_rd_d       = ent_rd_q;
      ent_funct3_d   = ent_funct3_q;
      ent_off_d      = ent_off_q;
      ent_data_d     = ent_data_q;
      case (state_q)
         PEND: begin
            if (wb.dmem_rvalid) begin
               ent_data_d = ext_data;
               state_d    = READY;
            end
         end
         default: begin
            if (capture) begin
               ent_v_d        = 1'b1;
               ent_regwrite_d = wb.mem_RegWrite;
               ent_rd_d       = wb.mem_rd;
               ent_funct3_d   = wb.mem_funct3;
               ent_off_d      = wb.mem_alu_result[1:0];
               ent_data_d     = wb.mem_is_jal ? wb.mem_pc_plus4 : wb.mem_alu_result;
               state_d        = wb.mem_MemtoReg ? PEND : READY;
            end else begin
               ent_v_d = 1'b0;
               state_d = EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= EMPTY;
         ent_v_q        <= 1'b0;
         ent_regwrite_q <= 1'b0;
         ent_rd_q       <= '0;
         ent_funct3_q   <= '0;
         ent_off_q      <= '0;
         ent_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         ent_v_q        <= ent_v_d;
         ent_regwrite_q <= ent_regwrite_d;
         ent_rd_q       <= ent_rd_d;
         ent_funct3_q   <= ent_funct3_d;
         ent_off_q      <= ent_off_d;
         ent_data_q     <= ent_data_d;
      end
   end

   assign wb.wb_stall       = stall;
   assign wb.RegWrite       = (state_q == READY) && ent_v_q && ent_regwrite_q && (ent_rd_q != 5'd0);
   assign wb.Write_data     = ent_data_q;
   assign wb.Write_register = ent_rd_q;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   always_comb begin
      instret_d = instret_q;
      if (state_q == READY) begin
         instret_d = instret_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= 64'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign wb.instret = instret_q;
`else
   assign wb.instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus hand-written sequences.
module tb_wb_stage;
   import pipeline_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [63:0] exp_instret;

   wb_stage_if #(.XLEN(32)) bus ();

   wb_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        load;
      logic        jal;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] exp_data;
      logic        exp_we;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.mem_valid      = 1'b0;
      bus.mem_RegWrite   = 1'b0;
      bus.mem_MemtoReg   = 1'b0;
      bus.mem_is_jal     = 1'b0;
      bus.mem_funct3     = 3'b000;
      bus.mem_rd         = 5'd0;
      bus.mem_alu_result = 32'h0;
      bus.mem_pc_plus4   = 32'h0;
      bus.dmem_rvalid    = 1'b0;
      bus.dmem_rdata     = 32'h0;
   endtask

   task automatic drive_op(input logic load, input logic jal, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
      bus.mem_valid      = 1'b1;
      bus.mem_RegWrite   = 1'b1;
      bus.mem_MemtoReg   = load;
      bus.mem_is_jal     = jal;
      bus.mem_funct3     = f3;
      bus.mem_rd         = rd;
      bus.mem_alu_result = alu;
      bus.mem_pc_plus4   = pc4;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      drive_op(v.load, v.jal, v.f3, v.rd, v.alu, v.pc4);
      @(negedge clk);
      idle_inputs();
      if (v.load) begin
         for (int i = 0; i < v.lat; i++) begin
            chk({v.name, " stall"}, {63'd0, bus.wb_stall}, 64'd1);
            chk({v.name, " no_we_pend"}, {63'd0, bus.RegWrite}, 64'd0);
            if (i == v.lat - 1) begin
               bus.dmem_rvalid = 1'b1;
               bus.dmem_rdata  = v.rdata;
            end
            @(negedge clk);
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = 32'h0;
         end
      end
      chk({v.name, " we"}, {63'd0, bus.RegWrite}, {63'd0, v.exp_we});
      chk({v.name, " stall_commit"}, {63'd0, bus.wb_stall}, 64'd0);
      chk({v.name, " data"}, {32'd0, bus.Write_data}, {32'd0, v.exp_data});
      chk({v.name, " reg"}, {59'd0, bus.Write_register}, {59'd0, v.rd});
      chk({v.name, " instret_pre"}, bus.instret, exp_instret);
`ifdef WB_INSTRET_EN
      exp_instret = exp_instret + 64'd1;
`endif
      @(negedge clk);
      chk({v.name, " we_after"}, {63'd0, bus.RegWrite}, 64'd0);
      chk({v.name, " instret_post"}, bus.instret, exp_instret);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      exp_instret = 64'd0;
      //        name     load jal f3      rd    alu           pc4     rdata         lat exp_data      we
      vecs[0]  = '{"add",  0, 0, 3'b000, 5'd5,  32'h0000_1234, 32'h0, 32'h0,         0, 32'h0000_1234, 1};
      vecs[1]  = '{"lb",   1, 0, F3_LB,  5'd6,  32'h0000_1003, 32'h0, 32'h80FF_FF7F, 3, 32'hFFFF_FF80, 1};
      vecs[2]  = '{"lbu",  1, 0, F3_LBU, 5'd7,  32'h0000_1003, 32'h0, 32'h80FF_FF7F, 3, 32'h0000_0080, 1};
      vecs[3]  = '{"lh",   1, 0, F3_LH,  5'd8,  32'h0000_2002, 32'h0, 32'h8001_0000, 1, 32'hFFFF_8001, 1};
      vecs[4]  = '{"lw",   1, 0, F3_LW,  5'd9,  32'h0000_2001, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1};
      vecs[5]  = '{"jal",  0, 1, 3'b000, 5'd1,  32'h0000_0055, 32'h104, 32'h0,       0, 32'h0000_0104, 1};
      vecs[6]  = '{"x0",   0, 0, 3'b000, 5'd0,  32'h0000_0077, 32'h0, 32'h0,         0, 32'h0000_0077, 0};
      vecs[7]  = '{"lhu",  1, 0, F3_LHU, 5'd12, 32'h0000_3001, 32'h0, 32'h1234_ABCD, 1, 32'h0000_ABCD, 1};
      vecs[8]  = '{"lb1",  1, 0, F3_LB,  5'd13, 32'h0000_3001, 32'h0, 32'h0000_7F00, 2, 32'h0000_007F, 1};
      vecs[9]  = '{"f3_3", 1, 0, 3'b011, 5'd14, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1};
      vecs[10] = '{"lh0",  1, 0, F3_LH,  5'd15, 32'h0000_3000, 32'h0, 32'h1111_8000, 1, 32'hFFFF_8000, 1};

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst stall", {63'd0, bus.wb_stall}, 64'd0);
      chk("rst we", {63'd0, bus.RegWrite}, 64'd0);
      chk("rst data", {32'd0, bus.Write_data}, 64'd0);
      chk("rst reg", {59'd0, bus.Write_register}, 64'd0);
      chk("rst instret", bus.instret, 64'd0);
      rst = 1'b0;

      // Stray read response while empty must be ignored.
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      idle_inputs();
      chk("stray rvalid we", {63'd0, bus.RegWrite}, 64'd0);
      chk("stray rvalid stall", {63'd0, bus.wb_stall}, 64'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Three back-to-back ALU ops commit on consecutive cycles.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b0, 1'b0, 3'b000, 5'(10 + i), 32'h100 + 32'(i), 32'h0);
         @(negedge clk);
         chk("b2b we", {63'd0, bus.RegWrite}, 64'd1);
         chk("b2b reg", {59'd0, bus.Write_register}, 64'(10 + i));
         chk("b2b data", {32'd0, bus.Write_data}, 64'(32'h100 + 32'(i)));
      end
      idle_inputs();
      @(negedge clk);
`ifdef WB_INSTRET_EN
      exp_instret = exp_instret + 64'd3;
`endif
      chk("b2b we_after", {63'd0, bus.RegWrite}, 64'd0);
      chk("b2b instret", bus.instret, exp_instret);

      // Reset while a load is pending drops it; its late response is ignored.
      drive_op(1'b1, 1'b0, F3_LW, 5'd20, 32'h0000_4000, 32'h0);
      @(negedge clk);
      idle_inputs();
      chk("pend stall", {63'd0, bus.wb_stall}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("pend rst stall", {63'd0, bus.wb_stall}, 64'd0);
      chk("pend rst we", {63'd0, bus.RegWrite}, 64'd0);
      chk("pend rst data", {32'd0, bus.Write_data}, 64'd0);
      chk("pend rst reg", {59'd0, bus.Write_register}, 64'd0);
      chk("pend rst instret", bus.instret, 64'd0);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 32'h1234_5678;
      @(negedge clk);
      idle_inputs();
      chk("late rvalid we", {63'd0, bus.RegWrite}, 64'd0);
      chk("late rvalid stall", {63'd0, bus.wb_stall}, 64'd0);
      @(negedge clk);
      chk("late rvalid we2", {63'd0, bus.RegWrite}, 64'd0);
      chk("late rvalid data", {32'd0, bus.Write_data}, 64'd0);
      chk("late rvalid instret", bus.instret, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
